counter_monitor: RTL and testbench

//   Receive-side checker for the saturating up/down counter's cnt stream.

---
 rtl/counter_monitor.sv | 200 ++++++++++++++++++++
 tb/tb_counter_monitor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : counter_monitor
//  Description : Checks the cnt stream of a saturating up/down counter, infers
//                the step mode, reports saturation and latches the first error.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_monitor #(
    parameter int W       = 10,
    parameter int RST_VAL = -50,
    parameter int INC     = 5,
    parameter int DEC     = 9,
    parameter int INV     = -11,
    parameter int MAX     = 235,
    parameter int MIN     = -230,
    parameter int SC_W    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    cnt_in,
    input  logic            cnt_vld,
    output logic            mode_out,
    output logic            mode_vld,
    output logic            sat_hi,
    output logic            sat_lo,
    output logic [SC_W-1:0] step_cnt,
    output logic            err,
    output logic [2:0]      err_code
);

    localparam logic [1:0] S_WAIT_FIRST = 2'd0;
    localparam logic [1:0] S_TRACK      = 2'd1;
    localparam logic [1:0] S_RESYNC     = 2'd2;
    localparam logic [1:0] S_ERROR      = 2'd3;

    localparam logic [2:0] c_code_first = 3'd1;
    localparam logic [2:0] c_code_step  = 3'd2;
    localparam logic [2:0] c_code_inv   = 3'd3;
    localparam logic [2:0] c_code_range = 3'd4;

    // All value arithmetic is done one bit wider than the counter so deltas never wrap.
    localparam logic signed [W:0] c_rst_val   = (W+1)'(RST_VAL);
    localparam logic signed [W:0] c_inv       = (W+1)'(INV);
    localparam logic signed [W:0] c_max       = (W+1)'(MAX);
    localparam logic signed [W:0] c_min       = (W+1)'(MIN);
    localparam logic signed [W:0] c_inc       = (W+1)'(INC);
    localparam logic signed [W:0] c_inc2      = (W+1)'(2 * INC);
    localparam logic signed [W:0] c_ndec      = (W+1)'(-DEC);
    localparam logic signed [W:0] c_ndec2     = (W+1)'(-2 * DEC);
    localparam logic signed [W:0] c_up_skip   = (W+1)'(INV - INC);
    localparam logic signed [W:0] c_dn_skip   = (W+1)'(INV + DEC);
    localparam logic signed [W:0] c_hi_thresh = (W+1)'(MAX - INC);
    localparam logic signed [W:0] c_lo_thresh = (W+1)'(MIN + DEC);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [W-1:0]      r_prev;
    logic              r_mode_out;
    logic              r_mode_vld;
    logic              r_sat_hi;
    logic              r_sat_lo;
    logic [SC_W-1:0]   r_step_cnt;
    logic              r_err;
    logic [2:0]        r_err_code;

    logic signed [W:0] w_cur_x;
    logic signed [W:0] w_prev_x;
    logic signed [W:0] w_d;
    logic              w_oor;
    logic              w_is_inv;
    logic              w_up;
    logic              w_dn;
    logic              w_hold_hi;
    logic              w_hold_lo;
    logic              w_legal;

    logic              w_err_set;
    logic [2:0]        w_err_code;
    logic              w_step;
    logic              w_load_prev;
    logic              w_drop_vld;

    assign w_cur_x  = {cnt_in[W-1], cnt_in};
    assign w_prev_x = {r_prev[W-1], r_prev};
    assign w_d      = w_cur_x - w_prev_x;

    assign w_oor     = (w_cur_x > c_max) || (w_cur_x < c_min);
    assign w_is_inv  = (w_cur_x == c_inv);
    assign w_up      = ((w_d == c_inc) && (w_prev_x != c_up_skip)) ||
                       ((w_prev_x == c_up_skip) && (w_d == c_inc2));
    assign w_dn      = ((w_d == c_ndec) && (w_prev_x != c_dn_skip)) ||
                       ((w_prev_x == c_dn_skip) && (w_d == c_ndec2));
    assign w_hold_hi = (w_d == '0) && (w_prev_x > c_hi_thresh);
    assign w_hold_lo = (w_d == '0) && (w_prev_x < c_lo_thresh);
    assign w_legal   = w_up || w_dn || w_hold_hi || w_hold_lo;

    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        w_err_code  = 3'd0;
        w_step      = 1'b0;
        w_load_prev = 1'b0;
        w_drop_vld  = 1'b0;
        case (r_state)
            S_WAIT_FIRST: begin
                if (cnt_vld) begin
                    if (w_cur_x == c_rst_val) begin
                        w_load_prev = 1'b1;
                        w_state_nxt = S_TRACK;
                    end else begin
                        w_err_set  = 1'b1;
                        w_err_code = c_code_first;
                    end
                end
            end
            S_TRACK: begin
                if (!cnt_vld) begin
                    w_drop_vld  = 1'b1;
                    w_state_nxt = S_RESYNC;
                end else if (w_oor) begin
                    w_err_set  = 1'b1;
                    w_err_code = c_code_range;
                end else if (w_is_inv) begin
                    w_err_set  = 1'b1;
                    w_err_code = c_code_inv;
                end else if (w_legal) begin
                    w_step      = 1'b1;
                    w_load_prev = 1'b1;
                end else begin
                    w_err_set  = 1'b1;
                    w_err_code = c_code_step;
                end
            end
            S_RESYNC: begin
                // prev is stale after a gap, so only the absolute checks apply.
                if (cnt_vld) begin
                    if (w_oor) begin
                        w_err_set  = 1'b1;
                        w_err_code = c_code_range;
                    end else if (w_is_inv) begin
                        w_err_set  = 1'b1;
                        w_err_code = c_code_inv;
                    end else begin
                        w_load_prev = 1'b1;
                        w_state_nxt = S_TRACK;
                    end
                end
            end
            default: ;
        endcase
        if (w_err_set) begin
            w_state_nxt = S_ERROR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_WAIT_FIRST;
            r_prev     <= '0;
            r_mode_out <= 1'b0;
            r_mode_vld <= 1'b0;
            r_sat_hi   <= 1'b0;
            r_sat_lo   <= 1'b0;
            r_step_cnt <= '0;
            r_err      <= 1'b0;
            r_err_code <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_prev) begin
                r_prev <= cnt_in;
            end
            if (w_err_set) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
            end
            if (w_drop_vld) begin
                r_mode_vld <= 1'b0;
            end
            if (w_step) begin
                r_mode_out <= w_up || w_hold_hi;
                r_mode_vld <= 1'b1;
                r_sat_hi   <= w_hold_hi;
                r_sat_lo   <= w_hold_lo;
                if (r_step_cnt != {SC_W{1'b1}}) begin
                    r_step_cnt <= r_step_cnt + SC_W'(1);
                end
            end
        end
    end

    assign mode_out = r_mode_out;
    assign mode_vld = r_mode_vld;
    assign sat_hi   = r_sat_hi;
    assign sat_lo   = r_sat_lo;
    assign step_cnt = r_step_cnt;
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_counter_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_monitor
//  Description : Scoreboard bench for counter_monitor against a successor-based
//                reference model with directed and random counter streams.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_counter_monitor;

    localparam int W       = 10;
    localparam int RST_VAL = -50;
    localparam int INC     = 5;
    localparam int DEC     = 9;
    localparam int INV     = -11;
    localparam int MAX     = 235;
    localparam int MIN     = -230;
    localparam int SC_W    = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [W-1:0]    cnt_in = '0;
    logic            cnt_vld = 1'b0;
    logic            mode_out;
    logic            mode_vld;
    logic            sat_hi;
    logic            sat_lo;
    logic [SC_W-1:0] step_cnt;
    logic            err;
    logic [2:0]      err_code;

    always #5 clk = ~clk;

    counter_monitor #(
        .W(W), .RST_VAL(RST_VAL), .INC(INC), .DEC(DEC),
        .INV(INV), .MAX(MAX), .MIN(MIN), .SC_W(SC_W)
    ) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_vld(cnt_vld),
        .mode_out(mode_out), .mode_vld(mode_vld), .sat_hi(sat_hi),
        .sat_lo(sat_lo), .step_cnt(step_cnt), .err(err), .err_code(err_code)
    );

    typedef struct packed {
        logic            mode_out;
        logic            mode_vld;
        logic            sat_hi;
        logic            sat_lo;
        logic [SC_W-1:0] step_cnt;
        logic            err;
        logic [2:0]      err_code;
    } obs_t;

    obs_t q[$];
    obs_t mon_exp;
    obs_t mon_got;
    int   checks = 0;
    int   errors = 0;

    // Reference model: the monitor either waits for the first sample, follows a
    // trusted previous value, has lost trust after a gap, or is dead.
    localparam int P_WAIT = 0, P_FOLLOW = 1, P_LOST = 2, P_DEAD = 3;
    int   m_phase = P_WAIT;
    int   m_prev  = 0;
    obs_t m_o     = '0;

    function automatic int succ_up(input int cur);
        int n = cur + INC;
        if (n == INV) n = n + INC;
        return n;
    endfunction

    function automatic int succ_dn(input int cur);
        int n = cur - DEC;
        if (n == INV) n = n - DEC;
        return n;
    endfunction

    task automatic m_fail(input int code);
        m_o.err      = 1'b1;
        m_o.err_code = 3'(code);
        m_phase      = P_DEAD;
    endtask

    task automatic m_step(input bit up, input bit hi, input bit lo, input int x);
        m_o.mode_out = up;
        m_o.mode_vld = 1'b1;
        m_o.sat_hi   = hi;
        m_o.sat_lo   = lo;
        if (m_o.step_cnt != 16'hFFFF) m_o.step_cnt = m_o.step_cnt + 16'd1;
        m_prev = x;
    endtask

    task automatic model(input bit r, input bit v, input int x);
        if (r) begin
            m_o = '0; m_phase = P_WAIT; m_prev = 0;
            return;
        end
        if (!v) begin
            if (m_phase == P_FOLLOW) begin
                m_phase = P_LOST; m_o.mode_vld = 1'b0;
            end
            return;
        end
        case (m_phase)
            P_WAIT: begin
                if (x == RST_VAL) begin m_prev = x; m_phase = P_FOLLOW; end
                else m_fail(1);
            end
            P_FOLLOW, P_LOST: begin
                if (x > MAX || x < MIN) m_fail(4);
                else if (x == INV) m_fail(3);
                else if (m_phase == P_LOST) begin m_prev = x; m_phase = P_FOLLOW; end
                else if (x == succ_up(m_prev)) m_step(1, 0, 0, x);
                else if (x == succ_dn(m_prev)) m_step(0, 0, 0, x);
                else if (x == m_prev && m_prev + INC > MAX) m_step(1, 1, 0, x);
                else if (x == m_prev && m_prev - DEC < MIN) m_step(0, 0, 1, x);
                else m_fail(2);
            end
            default: ;
        endcase
    endtask

    // One clock of stimulus; expectation is queued once the edge has sampled it.
    task automatic cyc(input bit r, input bit v, input int x);
        logic signed [W-1:0] t;
        t       = x[W-1:0];
        rst     = r;
        cnt_vld = v;
        cnt_in  = t;
        model(r, v, int'(t));
        @(posedge clk);
        #1;
        q.push_back(m_o);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                mon_exp = q.pop_front();
                mon_got = {mode_out, mode_vld, sat_hi, sat_lo, step_cnt, err, err_code};
                checks++;
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL outputs @%0t: got mode=%0d vld=%0d hi=%0d lo=%0d steps=%0d err=%0d code=%0d, want mode=%0d vld=%0d hi=%0d lo=%0d steps=%0d err=%0d code=%0d",
                             $time, mon_got.mode_out, mon_got.mode_vld, mon_got.sat_hi,
                             mon_got.sat_lo, mon_got.step_cnt, mon_got.err, mon_got.err_code,
                             mon_exp.mode_out, mon_exp.mode_vld, mon_exp.sat_hi,
                             mon_exp.sat_lo, mon_exp.step_cnt, mon_exp.err, mon_exp.err_code);
                end
            end
        end
    end

    function automatic int legal_next(input int cur, input bit up);
        int n;
        if (up) begin
            n = succ_up(cur);
            if (n > MAX) n = cur;
        end else begin
            n = succ_dn(cur);
            if (n < MIN) n = cur;
        end
        return n;
    endfunction

    task automatic start();
        cyc(1, 0, 0);
        cyc(0, 1, RST_VAL);
    endtask

    task automatic walk(inout int val, input bit up, input int n);
        for (int i = 0; i < n; i++) begin
            val = legal_next(val, up);
            cyc(0, 1, val);
        end
    endtask

    int g_val;
    bit g_up;
    int rr;
    int waitc;

    initial begin
        // basic up steps
        start();
        cyc(0, 1, -45); cyc(0, 1, -40);
        // up to 25, then down across -2 -> -20 (skips INV)
        start(); g_val = RST_VAL;
        walk(g_val, 1'b1, 15);
        walk(g_val, 1'b0, 5);
        // top saturation with holds
        start(); g_val = RST_VAL;
        walk(g_val, 1'b1, 60);
        // bottom saturation with holds
        start(); g_val = RST_VAL;
        walk(g_val, 1'b0, 23);
        // illegal step, then frozen
        start();
        cyc(0, 1, -45); cyc(0, 1, -37); cyc(0, 1, -32); cyc(0, 1, -27);
        // bad first sample, INV, out of range after gap
        cyc(1, 0, 0); cyc(0, 1, -45); cyc(0, 1, -50);
        start(); cyc(0, 1, INV);
        start(); cyc(0, 0, 0); cyc(0, 1, 300); cyc(0, 1, 5);
        // gap then resync
        start();
        cyc(0, 1, -45);
        cyc(0, 0, 77); cyc(0, 0, 12); cyc(0, 0, -3);
        cyc(0, 1, 0); cyc(0, 1, 5);
        // reset wins over a simultaneous valid sample
        cyc(1, 1, -45); cyc(0, 1, -50); cyc(0, 1, -41);

        for (int s = 0; s < 8; s++) begin
            start(); g_val = RST_VAL; g_up = 1'($urandom % 2);
            for (int i = 0; i < 250; i++) begin
                rr = $urandom_range(0, 99);
                if (rr < 4) begin
                    cyc(0, 0, int'($urandom));
                    if ($urandom % 2 == 0) begin
                        g_val = $urandom_range(0, MAX - MIN) + MIN;
                        if (g_val == INV) g_val = 0;
                    end
                end else if (rr < 5) begin
                    cyc(0, 1, $urandom_range(0, 1023) - 512);
                end else if (rr < 6) begin
                    cyc(1, 1'($urandom % 2), int'($urandom));
                    cyc(0, 1, RST_VAL); g_val = RST_VAL;
                end else begin
                    if (rr < 9) g_up = ~g_up;
                    g_val = legal_next(g_val, g_up);
                    cyc(0, 1, g_val);
                end
            end
        end

        cnt_vld = 1'b0;
        waitc = 0;
        while (q.size() > 0 && waitc < 20) begin
            @(posedge clk);
            waitc++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
